// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
//  Start/done handshake and operand/result bundle for seq_divider.
//  Optional macro: SEQ_DIV_SIGNED_EN adds the div_signed request bit.
//  Signals:
//   start       request, sampled by the divider only while it is not busy
//   dividend    2N-bit dividend, captured on the accepted start edge
//   divisor     N-bit divisor, captured on the accepted start edge
//   div_signed  (SEQ_DIV_SIGNED_EN only) operands are two's complement
//   busy        divider is iterating
//   done        one-cycle pulse; results and flags valid from this cycle
//   quotient    N-bit quotient, held until the next result
//   remainder   N-bit remainder, held until the next result
//   div_zero    divisor was zero
//   overflow    quotient did not fit in N bits
//  Modports: master = requester, slave = divider.
// ---------------------------------------------------------------------------
interface seq_divider_if #(
   parameter int N = 32
);
   logic             start;
   logic [2*N-1:0]   dividend;
   logic [N-1:0]     divisor;
`ifdef SEQ_DIV_SIGNED_EN
   logic             div_signed;
`endif
   logic             busy;
   logic             done;
   logic [N-1:0]     quotient;
   logic [N-1:0]     remainder;
   logic             div_zero;
   logic             overflow;

   modport master (
`ifdef SEQ_DIV_SIGNED_EN
      output div_signed,
`endif
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero, overflow
   );

   modport slave (
`ifdef SEQ_DIV_SIGNED_EN
      input  div_signed,
`endif
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero, overflow
   );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//  Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit
//  quotient and N-bit remainder, one quotient bit per clock.
//  Optional macro: SEQ_DIV_SIGNED_EN adds signed operation (div_signed bit,
//  FIX state for sign correction, signed overflow detection).
//  Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset; aborts any running operation
//   div_if  seq_divider_if.slave: start/operands in, busy/done/results out
//  Timing: unsigned op accepted in cycle c -> busy c+1..c+N, done at c+N+1.
//  Errors (div by zero, quotient too wide) skip RUN: done at c+1.
// ---------------------------------------------------------------------------
module seq_divider #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave div_if
);
   localparam int CW = $clog2(N);

`ifdef SEQ_DIV_SIGNED_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
   localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [N-1:0]    rem_q;          // partial remainder (always < divisor)
   logic [N-1:0]    quo_q;          // dividend low bits shift out, quotient bits shift in
   logic [N-1:0]    dvs_q;
   logic [N-1:0]    quotient_q, remainder_q;
   logic            div_zero_q, overflow_q;

   logic            accept;
   logic [2*N-1:0]  dvd_mag;
   logic [N-1:0]    dvs_mag;
   logic            in_zero, in_ovf, in_err;
   logic [N:0]      shifted, diff;
   logic            fits;
   logic [N-1:0]    rem_nx, quo_nx;
   logic            last_iter;
   logic            run_ovf;

   assign accept = div_if.start && (state_q == S_IDLE || state_q == S_DONE);

`ifdef SEQ_DIV_SIGNED_EN
   logic            dvd_neg, dvs_neg;
   logic            signed_q, q_neg_q, r_neg_q;
   logic [N-1:0]    lo_raw_q;       // raw dividend low half, for the late overflow result

   assign dvd_neg = div_if.div_signed & div_if.dividend[2*N-1];
   assign dvs_neg = div_if.div_signed & div_if.divisor[N-1];
   assign dvd_mag = dvd_neg ? -div_if.dividend : div_if.dividend;
   assign dvs_mag = dvs_neg ? -div_if.divisor  : div_if.divisor;
`else
   assign dvd_mag = div_if.dividend;
   assign dvs_mag = div_if.divisor;
`endif

   // A magnitude quotient wider than N bits is an error for either mode,
   // so it is caught before any iteration is spent.
   assign in_zero = (div_if.divisor == '0);
   assign in_ovf  = !in_zero && (dvd_mag[2*N-1:N] >= dvs_mag);
   assign in_err  = in_zero | in_ovf;

   // One restoring step. Since rem_q < divisor, shifted < 2*divisor, so the
   // top bit of the N+1-bit difference is exactly the borrow.
   assign shifted   = {rem_q, quo_q[N-1]};
   assign diff      = shifted - {1'b0, dvs_q};
   assign fits      = ~diff[N];
   assign rem_nx    = fits ? diff[N-1:0] : shifted[N-1:0];
   assign quo_nx    = {quo_q[N-2:0], fits};
   assign last_iter = (cnt_q == CW'(N-1));

`ifdef SEQ_DIV_SIGNED_EN
   // Largest positive quotient is 2^(N-1)-1; -2^(N-1) is still representable.
   assign run_ovf = signed_q && (quo_nx > MAX_POS) && !(quo_nx == MIN_NEG && q_neg_q);
`else
   assign run_ovf = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (div_if.start) state_d = in_err ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (last_iter) begin
`ifdef SEQ_DIV_SIGNED_EN
               state_d = (signed_q && !run_ovf) ? S_FIX : S_DONE;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef SEQ_DIV_SIGNED_EN
         S_FIX:  state_d = S_DONE;
`endif
         S_DONE: begin
            if (div_if.start) state_d = in_err ? S_DONE : S_RUN;
            else              state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      div_if.busy = 1'b0;
      div_if.done = 1'b0;
      case (state_q)
         S_RUN:  div_if.busy = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
         S_FIX:  div_if.busy = 1'b1;
`endif
         S_DONE: div_if.done = 1'b1;
         default: ;
      endcase
   end

   assign div_if.quotient  = quotient_q;
   assign div_if.remainder = remainder_q;
   assign div_if.div_zero  = div_zero_q;
   assign div_if.overflow  = overflow_q;

   // ---------------- datapath ----------------
   // Result registers are written only on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         signed_q    <= 1'b0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         lo_raw_q    <= '0;
`endif
      end else if (accept) begin
         cnt_q <= '0;
         rem_q <= dvd_mag[2*N-1:N];
         quo_q <= dvd_mag[N-1:0];
         dvs_q <= dvs_mag;
`ifdef SEQ_DIV_SIGNED_EN
         signed_q <= div_if.div_signed;
         q_neg_q  <= dvd_neg ^ dvs_neg;
         r_neg_q  <= dvd_neg;
         lo_raw_q <= div_if.dividend[N-1:0];
`endif
         if (in_err) begin
            quotient_q  <= '1;
            remainder_q <= div_if.dividend[N-1:0];
            div_zero_q  <= in_zero;
            overflow_q  <= in_ovf;
         end
      end else if (state_q == S_RUN) begin
         rem_q <= rem_nx;
         quo_q <= quo_nx;
         if (last_iter) begin
            cnt_q <= '0;
            if (run_ovf) begin
`ifdef SEQ_DIV_SIGNED_EN
               quotient_q  <= '1;
               remainder_q <= lo_raw_q;
               div_zero_q  <= 1'b0;
               overflow_q  <= 1'b1;
`endif
            end else begin
`ifdef SEQ_DIV_SIGNED_EN
               if (!signed_q) begin
                  quotient_q  <= quo_nx;
                  remainder_q <= rem_nx;
                  div_zero_q  <= 1'b0;
                  overflow_q  <= 1'b0;
               end
`else
               quotient_q  <= quo_nx;
               remainder_q <= rem_nx;
               div_zero_q  <= 1'b0;
               overflow_q  <= 1'b0;
`endif
            end
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
`ifdef SEQ_DIV_SIGNED_EN
      else if (state_q == S_FIX) begin
         // Quotient sign = XOR of operand signs; remainder follows the dividend.
         quotient_q  <= q_neg_q ? -quo_q : quo_q;
         remainder_q <= r_neg_q ? -rem_q : rem_q;
         div_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end
`endif
   end
endmodule
